aes256_key_expand: RTL
======================

Name: aes256_key_expand

Overview:
- Iterative AES-256 key-schedule engine. It accepts one 256-bit cipher key and emits the 15 round keys RK0..RK14 (128 bit each) in order over a valid/ready stream.
- Sits directly upstream of the round datapath and directly downstream of the existing `rcon` block. It drives rcon's 4-bit `index` and consumes its 32-bit `out`.
- One round key is generated per accepted output beat.

Parameters:
- NUM_RK, 15, number of round keys emitted (fixed for AES-256; not for override).
- RK_W, 128, round-key width in bits.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high. Applies to all state.
- key_in  in  256  cipher key; word w0 = key_in[255:224], ..., w7 = key_in[31:0].
- key_valid  in  1  key offer.
- key_ready  out  1  engine idle; key accepted when key_valid && key_ready.
- rk_valid  out  1  rk_data/rk_index valid.
- rk_ready  in  1  consumer accepts the beat when rk_valid && rk_ready.
- rk_index  out  4  round number of rk_data, 0..14.
- rk_data  out  128  round key, words w[4k]..w[4k+3], MSB word first.
- busy  out  1  high from key acceptance until RK14 is accepted.

Behaviour:
- State: 256-bit window register W, 4-bit idx, FSM {IDLE, EMIT} (plus CALC, see Optional Feature).
- Reset values: key_ready=1, rk_valid=0, rk_index=0, rk_data=0, busy=0, W=0, FSM=IDLE.
- IDLE:
  - key_ready=1.
  - On key accept: W<=key_in, idx<=0, next state EMIT.
  - rk_valid=1 on the cycle after acceptance (latency 1).
- EMIT, output selection:
  - rk_valid=1, key_ready=0, rk_index=idx.
  - rk_data = W[255:128] when idx==0, else W[127:0].
- rk_data and rk_index are held stable while rk_valid && !rk_ready.
- Accept of idx 0: idx<=1; W unchanged.
- Accept of idx k, 1<=k<=13, with j=k+1:
  - W<={W[127:0], F(W,j)}, idx<=j.
  - The next beat is valid the following cycle, so full throughput is 1 key/cycle.
- F(W,j):
  - j even: t = SubWord(RotWord(W[31:0])) ^ rcon_out, where rcon index = j/2-1 (range 0..6).
  - j odd: t = SubWord(W[31:0]); rcon output unused.
  - n0 = W[255:224]^t; n1 = W[223:192]^n0; n2 = W[191:160]^n1; n3 = W[159:128]^n2.
  - F = {n0,n1,n2,n3}.
- RotWord rotates bytes left by one. SubWord applies the AES S-box to each byte. All XOR is bitwise 32-bit; there is no carry.
- Accept of idx 14: next state IDLE, rk_valid<=0, busy<=0, key_ready<=1. A new key can be accepted the cycle after.
- key_valid outside IDLE is ignored; no queuing.
- rst asserted mid-sequence: immediate return to reset values; the partial sequence is discarded.
- rcon index is driven 0 whenever the FSM is not computing an even j.

Optional Feature:
- Macro KEY_EXP_REG_SBOX_EN.
- Defined:
  - A register follows SubWord/rcon (t is registered).
  - Accepting idx k (1..13) enters CALC for one cycle with rk_valid=0, then EMIT with the new key. Throughput is 1 key per 2 cycles.
  - The idx 0 accept and the key-load latency are unchanged.
  - Total from key accept to RK14 valid is 28 cycles with rk_ready tied high.
- Undefined: behaviour exactly as above; total is 15 cycles.

Decomposition:
- Shared package aes_pkg:
  - AES_NR=14, AES_NUM_RK=15, AES_RK_W=128, AES_KEY_W=256.
  - FSM state encoding.
  - Word/byte typedefs.
- Sub-module aes_subword: 32-bit combinational, four S-box lookups. It is also reusable by the round datapath.
- rcon is instantiated as-is.

Test Plan:
- FIPS-197 A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, rk_ready=1:
  - RK0 = 603deb1015ca71be2b73aef0857d7781.
  - RK1 = 1f352c073b6108d72d9810a30914dff4.
  - RK2 = 9ba354118e6925afa51a8b5f2067fcde.
  - RK3 = a8b09c1a93d194cdbe49846eb75d5b9a.
  - RK14 = fe4890d1e6188d0b046df344706c631e.
  - rk_index 0..14 consecutive; busy drops after RK14.
- Same key with rk_ready toggling pseudo-randomly: identical sequence; data/index stable during stalls; no skipped or duplicated index.
- key_valid held high throughout a sequence with a different key: ignored until key_ready; the second key loads the cycle after RK14 is accepted.
- rst pulsed while rk_index=7: outputs at reset values within the reset; a following all-zero key yields RK2 = 62636363626363636263636362636363.
- Back-to-back keys with rk_ready=1: second RK0 valid 2 cycles after first RK14 accept (1 for key_ready, 1 load).
- With KEY_EXP_REG_SBOX_EN: A.3 vector gives the same keys; RK14 valid exactly 28 cycles after key accept.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, key-schedule FSM encoding, word/byte types and the window update helper
package aes_pkg;
  localparam int AES_NR     = 14;
  localparam int AES_NUM_RK = 15;
  localparam int AES_RK_W   = 128;
  localparam int AES_KEY_W  = 256;
  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, EMIT, CALC} state_t;
  function automatic logic [AES_RK_W-1:0] next_half(input logic [AES_RK_W-1:0] hi, input word_t t);
    word_t n0, n1, n2, n3;
    n0 = hi[127:96] ^ t;
    n1 = hi[95:64]  ^ n0;
    n2 = hi[63:32]  ^ n1;
    n3 = hi[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction
endpackage

// File: rtl/aes_subword.sv
// aes_subword: combinational SubWord, four parallel AES S-box lookups
module aes_subword
  import aes_pkg::*;
(
  input  word_t w,
  output word_t s
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign s[8*i +: 8] = SBOX[w[8*i +: 8]];
  end
endmodule

// File: rtl/rcon.sv
// rcon: AES round constant word for a 0-based round index
module rcon (
  input  logic [3:0]  index,
  output logic [31:0] out
);
  localparam logic [0:15][7:0] RC = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                     8'h1b, 8'h36, 48'h0};
  assign out = {RC[index], 24'h0};
endmodule

// File: rtl/aes256_key_expand.sv
// aes256_key_expand: iterative AES-256 key schedule streaming RK0..RK14; KEY_EXP_REG_SBOX_EN registers the SubWord/rcon stage
module aes256_key_expand
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [3:0]           rk_index,
  output logic [AES_RK_W-1:0]  rk_data,
  output logic                 busy
);
  localparam int NUM_RK = AES_NUM_RK;
  localparam int RK_W = AES_RK_W;
  localparam logic [3:0] LAST = 4'(NUM_RK - 1);
`ifdef KEY_EXP_REG_SBOX_EN
  localparam state_t STEP = CALC;
`else
  localparam state_t STEP = EMIT;
`endif
  state_t state, state_nx;
  logic [AES_KEY_W-1:0] win;
  logic [3:0] idx, rc_idx;
  word_t rc_out, sw_in, sw_out, t, t_use;
  logic rk_acc, mid, shift, inc;
  assign rk_acc = rk_valid && rk_ready;
  assign mid = idx != 4'd0 && idx != LAST;
  // odd idx means the next key index j is even: RotWord plus rcon[j/2-1]
  assign rc_idx = (state == EMIT && mid && idx[0]) ? idx >> 1 : 4'd0;
  assign sw_in = idx[0] ? {win[23:0], win[31:24]} : win[31:0];
  assign t = sw_out ^ (idx[0] ? rc_out : 32'h0);
  rcon u_rcon (.index(rc_idx), .out(rc_out));
  aes_subword u_subword (.w(sw_in), .s(sw_out));
`ifdef KEY_EXP_REG_SBOX_EN
  word_t t_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) t_q <= '0;
    else if (rk_acc && mid) t_q <= t;
  assign t_use = t_q;
  assign shift = state == CALC;
  assign inc = state == CALC || (rk_acc && idx == 4'd0);
`else
  assign t_use = t;
  assign shift = rk_acc && mid;
  assign inc = rk_acc;
`endif
  assign key_ready = state == IDLE;
  assign rk_valid = state == EMIT;
  assign busy = state != IDLE;
  assign rk_index = idx;
  assign rk_data = rk_valid ? (idx == 4'd0 ? win[2*RK_W-1:RK_W] : win[RK_W-1:0]) : '0;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (key_valid ? EMIT : IDLE)
             : state == CALC ? EMIT
             : !rk_ready ? EMIT
             : idx == LAST ? IDLE
             : idx == 4'd0 ? EMIT
             : STEP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      win <= '0;
      idx <= '0;
    end else begin
      state <= state_nx;
      if (key_ready && key_valid) begin
        win <= key_in;
        idx <= '0;
      end else begin
        if (shift) win <= {win[RK_W-1:0], next_half(win[2*RK_W-1:RK_W], t_use)};
        if (rk_acc && idx == LAST) idx <= '0;
        else if (inc) idx <= idx + 4'd1;
      end
    end
endmodule
